// File: rtl/spi_io_host_pkg.sv
// Shared types and command codes for the SPI I/O host controller.
package spi_io_host_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_LOW,
    ST_HIGH,
    ST_HOLD
  } state_t;

  localparam logic [7:0] CMD_BUT_SW       = 8'h01;
  localparam logic [7:0] CMD_IKBD_IN      = 8'h02;
  localparam logic [7:0] CMD_IKBD_OUT     = 8'h03;
  localparam logic [7:0] CMD_SERIAL_IN    = 8'h04;
  localparam logic [7:0] CMD_SERIAL_OUT   = 8'h05;
  localparam logic [7:0] CMD_PARALLEL_OUT = 8'h06;
  localparam logic [7:0] CMD_MIDI_OUT     = 8'h08;
  localparam logic [7:0] CMD_ETH_MAC      = 8'h09;
  localparam logic [7:0] CMD_ETH_STATUS   = 8'h0A;
  localparam logic [7:0] CMD_ETH_TX_READ  = 8'h0B;
  localparam logic [7:0] CMD_ETH_RX_WRITE = 8'h0C;
  localparam logic [7:0] CMD_JOY0         = 8'h10;
  localparam logic [7:0] CMD_JOY1         = 8'h11;
  localparam logic [7:0] CMD_JOY2         = 8'h12;
  localparam logic [7:0] CMD_JOY3         = 8'h13;

endpackage

// File: rtl/spi_io_host_if.sv
// Host-side request/response bundle of the SPI I/O host.
interface spi_io_host_if;
  logic       start;
  logic [7:0] cmd;
  logic [3:0] len;
  logic [7:0] tx_data;
  logic       tx_req;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [3:0] rx_idx;
  logic       busy;
  logic       done;

  modport master (
    output start, cmd, len, tx_data,
    input  tx_req, rx_data, rx_valid, rx_idx, busy, done
  );

  modport slave (
    input  start, cmd, len, tx_data,
    output tx_req, rx_data, rx_valid, rx_idx, busy, done
  );
endinterface

// File: rtl/spi_half_tick.sv
// SPI half-period timer: down-counter reloaded on state entry, tick at zero.
module spi_half_tick #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick,
  output logic pre_tick
);

  localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

  logic [7:0] cnt;
  logic [7:0] cnt_next;

  always_comb begin
    cnt_next = (clear || cnt == 8'd0) ? RELOAD : cnt - 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt <= RELOAD;
    else       cnt <= cnt_next;
  end

  assign tick     = (cnt == 8'd0);
  // Lets the FSM register a pulse that lands in the last cycle of a phase.
  assign pre_tick = (cnt_next == 8'd0);

endmodule

// File: rtl/spi_io_host.sv
// SPI frame master: command byte plus up to 15 payload bytes, full duplex.
//
// state    | meaning
// IDLE     | SS high, waiting for start
// SETUP    | SS low, one half-period before the first SPI_CLK edge
// LOW      | SPI_CLK low, MOSI updated on entry
// HIGH     | SPI_CLK high, MISO sampled on entry
// HOLD     | SS still low, one half-period after the last falling edge
module spi_io_host
  import spi_io_host_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic          clk,
  input  logic          reset,
  spi_io_host_if.slave  host,
  output logic          SPI_CLK,
  output logic          SPI_SS_IO,
  output logic          SPI_MOSI,
  input  logic          SPI_MISO
);

  state_t     state;
  logic [3:0] len_q;
  logic [2:0] bit_cnt;
  logic [3:0] byte_cnt;
  logic [7:0] tx_shift;
  logic [7:0] rx_shift;
  logic       rx_pend;
  logic       tick;
  logic       pre_tick;
  logic       accept;
  logic       clear;

  // A start coinciding with the done pulse is deliberately dropped.
  assign accept = host.start && !host.done;
  assign clear  = (state == ST_IDLE) ? accept : tick;

  spi_half_tick #(.CLK_DIV(CLK_DIV)) u_half_tick (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .tick     (tick),
    .pre_tick (pre_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      SPI_SS_IO     <= 1'b1;
      SPI_CLK       <= 1'b0;
      SPI_MOSI      <= 1'b0;
      host.tx_req   <= 1'b0;
      host.rx_valid <= 1'b0;
      host.rx_data  <= 8'h00;
      host.rx_idx   <= 4'd0;
      host.busy     <= 1'b0;
      host.done     <= 1'b0;
      len_q         <= 4'd0;
      bit_cnt       <= 3'd0;
      byte_cnt      <= 4'd0;
      tx_shift      <= 8'h00;
      rx_shift      <= 8'h00;
      rx_pend       <= 1'b0;
    end else begin
      host.done     <= 1'b0;
      host.rx_valid <= rx_pend;
      rx_pend       <= 1'b0;
      if (rx_pend) begin
        host.rx_data <= rx_shift;
        host.rx_idx  <= byte_cnt;
      end
      // Request lands in the final HIGH cycle of bit 0 when another byte follows.
      host.tx_req <= ((state == ST_LOW && tick) || (state == ST_HIGH && !tick))
                     && pre_tick && bit_cnt == 3'd0 && byte_cnt != len_q;

      case (state)
        ST_IDLE: begin
          if (accept) begin
            state     <= ST_SETUP;
            SPI_SS_IO <= 1'b0;
            host.busy <= 1'b1;
            len_q     <= host.len;
            tx_shift  <= host.cmd;
            bit_cnt   <= 3'd7;
            byte_cnt  <= 4'd0;
          end
        end
        ST_SETUP: begin
          if (tick) begin
            state    <= ST_LOW;
            SPI_MOSI <= tx_shift[7];
          end
        end
        ST_LOW: begin
          if (tick) begin
            state    <= ST_HIGH;
            SPI_CLK  <= 1'b1;
            rx_shift <= {rx_shift[6:0], SPI_MISO};
            rx_pend  <= (bit_cnt == 3'd0);
          end
        end
        ST_HIGH: begin
          if (tick) begin
            SPI_CLK <= 1'b0;
            if (bit_cnt != 3'd0) begin
              state    <= ST_LOW;
              bit_cnt  <= bit_cnt - 3'd1;
              SPI_MOSI <= tx_shift[6];
              tx_shift <= {tx_shift[6:0], 1'b0};
            end else if (byte_cnt != len_q) begin
              state    <= ST_LOW;
              bit_cnt  <= 3'd7;
              byte_cnt <= byte_cnt + 4'd1;
              SPI_MOSI <= host.tx_data[7];
              tx_shift <= host.tx_data;
            end else begin
              state    <= ST_HOLD;
              SPI_MOSI <= 1'b0;
            end
          end
        end
        ST_HOLD: begin
          if (tick) begin
            state     <= ST_IDLE;
            SPI_SS_IO <= 1'b1;
            host.busy <= 1'b0;
            host.done <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_io_host.sv
// Directed bench for spi_io_host: frame table plus abort and held-start sequences.
module tb_spi_io_host;
  import spi_io_host_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic SPI_CLK, SPI_SS_IO, SPI_MOSI, SPI_MISO;

  spi_io_host_if hif ();

  spi_io_host #(.CLK_DIV(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .host      (hif.slave),
    .SPI_CLK   (SPI_CLK),
    .SPI_SS_IO (SPI_SS_IO),
    .SPI_MOSI  (SPI_MOSI),
    .SPI_MISO  (SPI_MISO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  cmd;
    logic [3:0]  len;
    logic [31:0] tx;
    logic [31:0] slave;
    logic [31:0] exp_mosi;
    int          exp_ss;
    int          exp_clks;
    int          exp_txreq;
  } vec_t;

  vec_t vecs [5];

  int checks = 0;
  int errors = 0;

  logic [31:0] tx_word = 32'h0;
  logic [31:0] slave_word = 32'h0;
  logic [1:0]  tx_k = 2'd0;
  int          slave_bit = 0;

  // Payload source: advances on each accepted request, rewinds when idle.
  always @(posedge clk) begin
    if (!hif.busy)      tx_k <= 2'd0;
    else if (hif.tx_req) tx_k <= tx_k + 2'd1;
  end
  assign hif.tx_data = tx_word[8*(3-int'(tx_k)) +: 8];

  // Slave shifts out on SPI_CLK falling edges, MSB first, restarting when SS rises.
  always @(posedge SPI_SS_IO or negedge SPI_CLK) begin
    if (SPI_SS_IO) slave_bit = 0;
    else           slave_bit = slave_bit + 1;
  end
  assign SPI_MISO = (slave_bit < 32) ? slave_word[5'(31 - slave_bit)] : 1'b0;

  int          ss_low, clk_rises, tx_reqs, dones, rx_n, mosi_glitch;
  logic [31:0] mosi_bits;
  logic        spi_clk_prev, mosi_prev;
  logic [7:0]  rx_d [16];
  logic [3:0]  rx_i [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sample();
    if (!SPI_SS_IO) ss_low++;
    if (hif.tx_req) tx_reqs++;
    if (hif.done) dones++;
    if (hif.rx_valid && rx_n < 16) begin
      rx_d[rx_n] = hif.rx_data;
      rx_i[rx_n] = hif.rx_idx;
      rx_n++;
    end
    if (SPI_CLK && !spi_clk_prev) begin
      mosi_bits = {mosi_bits[30:0], SPI_MOSI};
      clk_rises++;
    end
    if (SPI_CLK && spi_clk_prev && SPI_MOSI != mosi_prev) mosi_glitch++;
    spi_clk_prev = SPI_CLK;
    mosi_prev    = SPI_MOSI;
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    int  cyc;
    bit  seen;
    ss_low = 0; clk_rises = 0; tx_reqs = 0; dones = 0; rx_n = 0; mosi_glitch = 0;
    mosi_bits = 32'h0; spi_clk_prev = 1'b0; mosi_prev = 1'b0;
    tx_word = v.tx;
    slave_word = v.slave;
    @(negedge clk);
    hif.cmd = v.cmd; hif.len = v.len; hif.start = 1'b1;
    @(negedge clk);
    hif.start = 1'b0;
    check({tag, "_busy_rise"}, 32'(hif.busy), 32'd1);
    seen = 1'b0;
    cyc = 0;
    while (!seen && cyc < 2000) begin
      sample();
      if (hif.done) seen = 1'b1;
      @(negedge clk);
      cyc++;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic check_frame(input vec_t v, input string tag);
    logic [7:0] exp_b;
    check({tag, "_ss_low"}, ss_low, v.exp_ss);
    check({tag, "_clks"}, clk_rises, v.exp_clks);
    check({tag, "_mosi"}, mosi_bits, v.exp_mosi);
    check({tag, "_txreq"}, tx_reqs, v.exp_txreq);
    check({tag, "_dones"}, dones, 1);
    check({tag, "_mosi_stable"}, mosi_glitch, 0);
    check({tag, "_rx_count"}, rx_n, int'(v.len) + 1);
    check({tag, "_busy_end"}, 32'(hif.busy), 32'd0);
    for (int j = 0; j <= int'(v.len) && j < 4; j++) begin
      exp_b = v.slave[31-8*j -: 8];
      check($sformatf("%s_rx%0d_data", tag, j), 32'(rx_d[j]), 32'(exp_b));
      check($sformatf("%s_rx%0d_idx", tag, j), 32'(rx_i[j]), j);
    end
  endtask

  initial begin
    int cyc, falls, gap;
    bit seen;
    logic prev_ss;

    vecs[0] = '{8'h01, 4'd1, 32'h0A000000, 32'hA35A0000, 32'h0000010A, 68, 16, 1};
    vecs[1] = '{8'h03, 4'd1, 32'hC5000000, 32'hC33C0000, 32'h000003C5, 68, 16, 1};
    vecs[2] = '{8'h0A, 4'd3, 32'h11223300, 32'hA3123456, 32'h0A112233, 132, 32, 3};
    vecs[3] = '{8'h10, 4'd0, 32'h00000000, 32'hA3000000, 32'h00000010, 36, 8, 0};
    vecs[4] = '{8'h13, 4'd2, 32'hFF000000, 32'h817EC300, 32'h0013FF00, 100, 24, 2};

    reset = 1'b1;
    hif.start = 1'b0; hif.cmd = 8'h00; hif.len = 4'd0;
    repeat (3) @(negedge clk);
    check("rst_ss", 32'(SPI_SS_IO), 32'd1);
    check("rst_clk", 32'(SPI_CLK), 32'd0);
    check("rst_mosi", 32'(SPI_MOSI), 32'd0);
    check("rst_busy", 32'(hif.busy), 32'd0);
    check("rst_done", 32'(hif.done), 32'd0);
    check("rst_txreq", 32'(hif.tx_req), 32'd0);
    check("rst_rxvalid", 32'(hif.rx_valid), 32'd0);
    check("rst_rxdata", 32'(hif.rx_data), 32'd0);
    check("rst_rxidx", 32'(hif.rx_idx), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_frame(vecs[i], $sformatf("v%0d", i));
      check_frame(vecs[i], $sformatf("v%0d", i));
      repeat (3) @(negedge clk);
    end

    // Reset in the 20th cycle of a len=2 frame aborts it without done.
    tx_word = vecs[4].tx;
    slave_word = vecs[4].slave;
    @(negedge clk);
    hif.cmd = 8'h13; hif.len = 4'd2; hif.start = 1'b1;
    @(negedge clk);
    hif.start = 1'b0;
    repeat (19) @(negedge clk);
    check("abort_ss_before", 32'(SPI_SS_IO), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("abort_ss", 32'(SPI_SS_IO), 32'd1);
    check("abort_clk", 32'(SPI_CLK), 32'd0);
    check("abort_busy", 32'(hif.busy), 32'd0);
    check("abort_done", 32'(hif.done), 32'd0);
    reset = 1'b0;
    dones = 0;
    repeat (5) begin
      @(negedge clk);
      if (hif.done) dones++;
    end
    check("abort_no_done", dones, 0);
    run_frame(vecs[4], "post_abort");
    check_frame(vecs[4], "post_abort");
    repeat (3) @(negedge clk);

    // Start held high: one frame, then a restart two cycles after done.
    tx_word = 32'h0;
    slave_word = 32'hA3000000;
    @(negedge clk);
    hif.cmd = CMD_JOY0; hif.len = 4'd0; hif.start = 1'b1;
    prev_ss = SPI_SS_IO;
    falls = 0; seen = 1'b0; cyc = 0;
    while (!seen && cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (prev_ss && !SPI_SS_IO) falls++;
      prev_ss = SPI_SS_IO;
      if (hif.done) seen = 1'b1;
    end
    check("hold_done_seen", 32'(seen), 32'd1);
    check("hold_one_frame", falls, 1);
    gap = 0; cyc = 0;
    while (SPI_SS_IO && cyc < 50) begin
      gap++;
      @(negedge clk);
      cyc++;
    end
    check("hold_gap", gap, 2);
    check("hold_restart", 32'(SPI_SS_IO), 32'd0);
    hif.start = 1'b0;
    seen = 1'b0; cyc = 0;
    while (!seen && cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (hif.done) seen = 1'b1;
    end
    check("hold_second_done", 32'(seen), 32'd1);
    @(negedge clk);
    check("hold_idle_after", 32'(hif.busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_io_host.md
SPI_IO_HOST -- requirements
Module: spi_io_host

Interface
REQ-001 Parameter: CLK_DIV, default 2, SPI half-period in clk cycles (legal 1..255).
REQ-002 clk  input  1  single system clock; all logic on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle frame request; sampled only in IDLE.
REQ-005 cmd  input  8  command byte; latched with start.
REQ-006 len  input  4  payload byte count 0..15; latched with start.
REQ-007 tx_data  input  8  payload byte; sampled in the cycle tx_req=1.
REQ-008 tx_req  output  1  one-cycle pulse requesting the next payload byte.
REQ-009 rx_data  output  8  byte shifted in from SPI_MISO.
REQ-010 rx_valid  output  1  one-cycle pulse; rx_data valid.
REQ-011 rx_idx  output  4  byte index of rx_data (0 = byte clocked during cmd).
REQ-012 busy  output  1  high from the cycle after start acceptance until done.
REQ-013 done  output  1  one-cycle pulse at frame end.
REQ-014 SPI_CLK  output  1  serial clock; idles low.
REQ-015 SPI_SS_IO  output  1  slave select, active-low; idles high.
REQ-016 SPI_MOSI  output  1  serial data out, MSB first.
REQ-017 SPI_MISO  input  1  serial data in, MSB first.

Function
REQ-018 States: IDLE, SETUP, LOW, HIGH, HOLD; IDLE->SETUP on start; SETUP->LOW after CLK_DIV cycles; LOW->HIGH and HIGH->LOW each after CLK_DIV cycles; HIGH->HOLD after the last bit of the last byte; HOLD->IDLE after CLK_DIV cycles.
REQ-019 Frame = cmd byte then len payload bytes; 8*(1+len) SPI_CLK periods; SPI_SS_IO low for exactly CLK_DIV*(2+16*(1+len)) cycles.
REQ-020 SPI_SS_IO goes low on the first cycle after start is sampled; busy rises on the same cycle.
REQ-021 SPI_MOSI changes only on entry to LOW (SPI_CLK low); stable throughout HIGH.
REQ-022 SPI_MISO is sampled on the clk cycle SPI_CLK rises (entry to HIGH), shifted in MSB first.
REQ-023 tx_req pulses one cycle before entry to LOW for bit 7 of each payload byte; tx_data is captured in that cycle; no tx_req when len=0.
REQ-024 rx_valid pulses on the cycle after the 8th sample of each byte, including byte 0; rx_idx increments 0..len.
REQ-025 done pulses on the cycle SPI_SS_IO returns high; busy falls on the same cycle.
REQ-026 start while busy is ignored; start in the done cycle is ignored; start on the following cycle is accepted.
REQ-027 Byte and bit counters are 4- and 3-bit; byte counter compares against latched len, never wraps within a frame.
REQ-028 SPI_MOSI driven 0 in IDLE, SETUP and HOLD.

Reset
REQ-029 On reset: state IDLE, SPI_SS_IO=1, SPI_CLK=0, SPI_MOSI=0, tx_req=0, rx_valid=0, done=0, busy=0, rx_data=0, rx_idx=0.
REQ-030 Reset mid-frame takes effect on the next clk edge: SPI_SS_IO high, SPI_CLK low, no done pulse; slave sees a frame abort.

Structure
REQ-031 Shared package holds the state enum and command constants: BUT_SW=01h, IKBD_IN=02h, IKBD_OUT=03h, SERIAL_IN=04h, SERIAL_OUT=05h, PARALLEL_OUT=06h, MIDI_OUT=08h, ETH_MAC=09h, ETH_STATUS=0Ah, ETH_TX_READ=0Bh, ETH_RX_WRITE=0Ch, JOY0..JOY3=10h..13h.
REQ-032 One sub-module, spi_half_tick: CLK_DIV counter producing a one-cycle tick, cleared on state entry.

Verification
REQ-033 CLK_DIV=2, start cmd=01h len=1 tx_data=0Ah -> MOSI bits 00000001 00001010; SS low exactly 68 cycles; one tx_req; done once.
REQ-034 Slave model returns core type A3h then 5Ah, cmd=03h len=1 -> rx_valid twice: (idx0,A3h), (idx1,5Ah).
REQ-035 cmd=0Ah len=3 with slave returning eth_status 12345678h -> rx bytes A3h,12h,34h,56h... idx 1..3 = 12h,34h,56h per slave byte order; 3 tx_req pulses.
REQ-036 len=0 cmd=10h -> 8 SPI_CLK periods, no tx_req, one rx_valid idx0, SS low 36 cycles.
REQ-037 reset asserted at the 20th cycle of a len=2 frame -> next cycle SS=1, SPI_CLK=0, busy=0, no done; new start then completes normally.
REQ-038 start held high through a frame -> exactly one frame; second frame begins only after done, with ≥1 idle cycle.
